mem_arbiter: RTL

Sits between the two L1 caches (instruction cache, data cache) and the single burst-oriented `bmem` port at the CPU boundary. It grants one cache-line transaction at a time, round-robin between clients. Each granted read is serialised into a 4-beat 64-bit burst request and the returned beats are reassembled into a 256-bit line. Each data-cache writeback is streamed out as 4 write beats.

---
 rtl/rv32i_types.sv | 16 +
 rtl/line_assembler.sv | 47 ++++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared types and sizes for the cache-to-bmem arbiter.
package rv32i_types;

  localparam int BURST_LEN = 4;
  localparam int BEAT_BITS = 64;
  localparam int LINE_BITS = BURST_LEN * BEAT_BITS;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_REQ   = 3'd1,
    RD_WAIT  = 3'd2,
    WR_BURST = 3'd3,
    DONE     = 3'd4
  } arb_state_t;

endpackage

// File: rtl/line_assembler.sv
// Beat counter plus 256-bit line register. On the read side it packs incoming
// 64-bit beats into the line; on the write side only the counter is used, to
// index the latched writeback line.
module line_assembler
  import rv32i_types::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 beat_valid,
  input  logic [BEAT_BITS-1:0] beat_data,
  output logic [LINE_BITS-1:0] line,
  output logic [1:0]           beat_cnt,
  output logic                 last_beat
);

  logic [LINE_BITS-1:0] line_q, line_d;
  logic [1:0]           cnt_q, cnt_d;

  // Next-state: clear wins over a beat; a beat lands at slot cnt_q.
  always_comb begin
    line_d = line_q;
    cnt_d  = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (beat_valid) begin
      line_d[{cnt_q, 6'b0} +: BEAT_BITS] = beat_data;
      cnt_d = cnt_q + 2'd1;
    end
  end

  // Counter and line storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_q <= '0;
      cnt_q  <= '0;
    end else begin
      line_q <= line_d;
      cnt_q  <= cnt_d;
    end
  end

  assign line      = line_q;
  assign beat_cnt  = cnt_q;
  assign last_beat = (cnt_q == 2'(BURST_LEN - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between icache and dcache onto a single burst bmem port.
// Reads become a 4-beat burst request whose returned beats are packed into a
// 256-bit line; dcache writebacks are streamed out as 4 write beats.
//
// bmem handshake: a request (bmem_read) or write beat (bmem_write) is held
// stable with its address/data until a cycle where bmem_ready=1, at which
// point it counts as accepted. Read beats arrive on bmem_rvalid with no
// back-pressure. Client side: requests are levels, held until the one-cycle
// resp pulse, and dropped the cycle after it.
module mem_arbiter
  import rv32i_types::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          i_addr,
  input  logic                 i_read,
  output logic [LINE_BITS-1:0] i_rdata,
  output logic                 i_resp,
  input  logic [31:0]          d_addr,
  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [LINE_BITS-1:0] d_wdata,
  output logic [LINE_BITS-1:0] d_rdata,
  output logic                 d_resp,
  output logic [31:0]          bmem_addr,
  output logic                 bmem_read,
  output logic                 bmem_write,
  output logic [BEAT_BITS-1:0] bmem_wdata,
  input  logic                 bmem_ready,
  input  logic [31:0]          bmem_raddr,
  input  logic [BEAT_BITS-1:0] bmem_rdata,
  input  logic                 bmem_rvalid,
  output arb_state_t           dbg_state
);

  arb_state_t           state_q;
  logic                 grant_q;       // 0 = icache, 1 = dcache
  logic                 last_grant_q;
  logic [31:0]          addr_q;
  logic [LINE_BITS-1:0] wline_q;
  logic [LINE_BITS-1:0] i_rdata_q;
  logic [LINE_BITS-1:0] d_rdata_q;

  logic                 i_req, d_req, pick_d;
  logic [31:0]          req_addr;
  logic                 asm_clear, asm_valid, asm_last;
  logic [1:0]           asm_cnt;
  logic [LINE_BITS-1:0] asm_line;
  logic                 unused_bits;

  // Arbitration: a lone request wins; on a tie the client not served last wins.
  always_comb begin
    i_req    = i_read;
    d_req    = d_read | d_write;
    pick_d   = d_req & (~i_req | ~last_grant_q);
    req_addr = pick_d ? d_addr : i_addr;
  end

  // The counter sits cleared while idle, so every grant starts at beat 0.
  assign asm_clear = (state_q == IDLE);
  assign asm_valid = ((state_q == RD_WAIT) & bmem_rvalid) |
                     ((state_q == WR_BURST) & bmem_ready);

  line_assembler u_line_assembler (
    .clk        (clk),
    .rst        (rst),
    .clear      (asm_clear),
    .beat_valid (asm_valid),
    .beat_data  (bmem_rdata),
    .line       (asm_line),
    .beat_cnt   (asm_cnt),
    .last_beat  (asm_last)
  );

  // Transaction FSM: grant, burst request/collect or write stream, completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b0;
      addr_q       <= '0;
      wline_q      <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_req | d_req) begin
            grant_q <= pick_d;
            addr_q  <= {req_addr[31:5], 5'b0};
            wline_q <= d_wdata;
            // A write takes priority over a simultaneous (illegal) read.
            state_q <= (pick_d & d_write) ? WR_BURST : RD_REQ;
          end
        end
        RD_REQ: begin
          if (bmem_ready) state_q <= RD_WAIT;
        end
        RD_WAIT: begin
          if (bmem_rvalid && asm_last) begin
            // The final beat always fills the top slot of the line.
            if (grant_q) d_rdata_q <= {bmem_rdata, asm_line[LINE_BITS-BEAT_BITS-1:0]};
            else         i_rdata_q <= {bmem_rdata, asm_line[LINE_BITS-BEAT_BITS-1:0]};
            state_q <= DONE;
          end
        end
        WR_BURST: begin
          if (bmem_ready && asm_last) state_q <= DONE;
        end
        DONE: begin
          last_grant_q <= grant_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from registered state only.
  assign bmem_read  = (state_q == RD_REQ);
  assign bmem_write = (state_q == WR_BURST);
  assign bmem_addr  = (bmem_read | bmem_write) ? addr_q : '0;
  assign bmem_wdata = bmem_write ? wline_q[{asm_cnt, 6'b0} +: BEAT_BITS] : '0;
  assign i_resp     = (state_q == DONE) & ~grant_q;
  assign d_resp     = (state_q == DONE) & grant_q;
  assign i_rdata    = i_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign dbg_state  = state_q;

  // Line offsets are dropped and the top line slot is taken from the beat bus.
  assign unused_bits = ^{i_addr[4:0], d_addr[4:0],
                         asm_line[LINE_BITS-1 -: BEAT_BITS], bmem_raddr};

  // Protocol checks on client and memory inputs.
  always @(posedge clk) begin
    if (rst) begin
      assert (!(d_read && d_write))
        else $error("d_read and d_write asserted together");
      assert (!(bmem_rvalid && (state_q != RD_WAIT)))
        else $error("bmem_rvalid outside RD_WAIT");
      if ((state_q == RD_WAIT) && bmem_rvalid)
        assert (bmem_raddr == addr_q)
          else $error("bmem_raddr %h does not match %h", bmem_raddr, addr_q);
    end
  end

endmodule
